// File: rtl/id_exe_reg.sv
// id_exe_reg: ID/EXE pipeline register with freeze (hold), flush (bubble) and a per-slot valid bit.
// A cleared slot is all zeros, so a bubble can never write, store, branch or update flags.
module id_exe_reg #(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          flush,
    input  logic          valid_in,
    input  logic [DW-1:0] pc_in,
    input  logic          wb_en_in,
    input  logic          mem_r_en_in,
    input  logic          mem_w_en_in,
    input  logic [3:0]    exe_cmd_in,
    input  logic          b_in,
    input  logic          s_in,
    input  logic          imm_in,
    input  logic [DW-1:0] val_rn_in,
    input  logic [DW-1:0] val_rm_in,
    input  logic [11:0]   shift_operand_in,
    input  logic [23:0]   signed_imm_24_in,
    input  logic [RW-1:0] dest_in,
    input  logic [RW-1:0] src1_in,
    input  logic [RW-1:0] src2_in,
    input  logic [3:0]    sr_in,
    output logic          valid_out,
    output logic [DW-1:0] pc_out,
    output logic          wb_en_out,
    output logic          mem_r_en_out,
    output logic          mem_w_en_out,
    output logic [3:0]    exe_cmd_out,
    output logic          b_out,
    output logic          s_out,
    output logic          imm_out,
    output logic [DW-1:0] val_rn_out,
    output logic [DW-1:0] val_rm_out,
    output logic [11:0]   shift_operand_out,
    output logic [23:0]   signed_imm_24_out,
    output logic [RW-1:0] dest_out,
    output logic [RW-1:0] src1_out,
    output logic [RW-1:0] src2_out,
    output logic [3:0]    sr_out,
    output logic          ldorst_out
);
    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic          wb_en;
        logic          mem_r_en;
        logic          mem_w_en;
        logic [3:0]    exe_cmd;
        logic          b;
        logic          s;
        logic          imm;
        logic [DW-1:0] val_rn;
        logic [DW-1:0] val_rm;
        logic [11:0]   shift_operand;
        logic [23:0]   signed_imm_24;
        logic [RW-1:0] dest;
        logic [RW-1:0] src1;
        logic [RW-1:0] src2;
        logic [3:0]    sr;
        logic          ldorst;
    } slot_t;

    slot_t in_s, slot_d, slot_q;

    always_comb begin
        in_s = '{
            valid:         1'b1,
            pc:            pc_in,
            wb_en:         wb_en_in,
            mem_r_en:      mem_r_en_in,
            mem_w_en:      mem_w_en_in,
            exe_cmd:       exe_cmd_in,
            b:             b_in,
            s:             s_in,
            imm:           imm_in,
            val_rn:        val_rn_in,
            val_rm:        val_rm_in,
            shift_operand: shift_operand_in,
            signed_imm_24: signed_imm_24_in,
            dest:          dest_in,
            src1:          src1_in,
            src2:          src2_in,
            sr:            sr_in,
            ldorst:        mem_r_en_in | mem_w_en_in
        };
        // flush beats freeze; an invalid ID slot loads as a bubble
        slot_d = flush ? '0 : freeze ? slot_q : valid_in ? in_s : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end

    assign valid_out         = slot_q.valid;
    assign pc_out            = slot_q.pc;
    assign wb_en_out         = slot_q.wb_en;
    assign mem_r_en_out      = slot_q.mem_r_en;
    assign mem_w_en_out      = slot_q.mem_w_en;
    assign exe_cmd_out       = slot_q.exe_cmd;
    assign b_out             = slot_q.b;
    assign s_out             = slot_q.s;
    assign imm_out           = slot_q.imm;
    assign val_rn_out        = slot_q.val_rn;
    assign val_rm_out        = slot_q.val_rm;
    assign shift_operand_out = slot_q.shift_operand;
    assign signed_imm_24_out = slot_q.signed_imm_24;
    assign dest_out          = slot_q.dest;
    assign src1_out          = slot_q.src1;
    assign src2_out          = slot_q.src2;
    assign sr_out            = slot_q.sr;
    assign ldorst_out        = slot_q.ldorst;
endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg: directed-vector bench for id_exe_reg with hand-computed expectations.
module tb_id_exe_reg;
    logic        clk = 0, rst, freeze, flush, valid_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in, sr_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic        valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, ldorst_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out, sr_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    int          n_pass = 0, n_total = 0;

    id_exe_reg #(.DW(32), .RW(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
        .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .exe_cmd_in(exe_cmd_in), .b_in(b_in), .s_in(s_in), .imm_in(imm_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .shift_operand_in(shift_operand_in),
        .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in), .src1_in(src1_in),
        .src2_in(src2_in), .sr_in(sr_in),
        .valid_out(valid_out), .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .exe_cmd_out(exe_cmd_out), .b_out(b_out), .s_out(s_out),
        .imm_out(imm_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
        .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .sr_out(sr_out),
        .ldorst_out(ldorst_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 32'(valid_out), 0);
        check({tag, ".pc"}, pc_out, 0);
        check({tag, ".wb_en"}, 32'(wb_en_out), 0);
        check({tag, ".mem_r"}, 32'(mem_r_en_out), 0);
        check({tag, ".mem_w"}, 32'(mem_w_en_out), 0);
        check({tag, ".exe_cmd"}, 32'(exe_cmd_out), 0);
        check({tag, ".b"}, 32'(b_out), 0);
        check({tag, ".s"}, 32'(s_out), 0);
        check({tag, ".imm"}, 32'(imm_out), 0);
        check({tag, ".val_rn"}, val_rn_out, 0);
        check({tag, ".val_rm"}, val_rm_out, 0);
        check({tag, ".shift"}, 32'(shift_operand_out), 0);
        check({tag, ".simm24"}, 32'(signed_imm_24_out), 0);
        check({tag, ".dest"}, 32'(dest_out), 0);
        check({tag, ".src1"}, 32'(src1_out), 0);
        check({tag, ".src2"}, 32'(src2_out), 0);
        check({tag, ".sr"}, 32'(sr_out), 0);
        check({tag, ".ldorst"}, 32'(ldorst_out), 0);
    endtask

    // advance one edge, then let outputs settle away from the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1; freeze = 1; flush = 0; valid_in = 1;
        pc_in = 32'h0000_0104; val_rn_in = 32'h55; val_rm_in = 32'hDEAD_BEEF;
        wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1; b_in = 1; s_in = 1; imm_in = 1;
        exe_cmd_in = 4'hF; dest_in = 4'hA; src1_in = 4'h3; src2_in = 4'h4; sr_in = 4'hF;
        shift_operand_in = 12'hFFF; signed_imm_24_in = 24'hABCDEF;
        step(); step();
        check_zero("reset");

        rst = 0; freeze = 0;
        wb_en_in = 0; mem_r_en_in = 1; mem_w_en_in = 0; b_in = 0; s_in = 1; imm_in = 1;
        shift_operand_in = 12'h0A3; val_rn_in = 32'h100; dest_in = 4'd5;
        src1_in = 4'd2; src2_in = 4'd9; sr_in = 4'b1010; signed_imm_24_in = 24'h00_1234;
        pc_in = 32'h0000_0108; exe_cmd_in = 4'b1001;
        step();
        check("load.valid", 32'(valid_out), 1);
        check("load.mem_r", 32'(mem_r_en_out), 1);
        check("load.mem_w", 32'(mem_w_en_out), 0);
        check("load.ldorst", 32'(ldorst_out), 1);
        check("load.shift", 32'(shift_operand_out), 32'h0A3);
        check("load.val_rn", val_rn_out, 32'h100);
        check("load.dest", 32'(dest_out), 5);
        check("load.src1", 32'(src1_out), 2);
        check("load.src2", 32'(src2_out), 9);
        check("load.sr", 32'(sr_out), 4'b1010);
        check("load.simm24", 32'(signed_imm_24_out), 32'h1234);
        check("load.pc", pc_out, 32'h108);
        check("load.exe_cmd", 32'(exe_cmd_out), 4'b1001);
        check("load.s", 32'(s_out), 1);
        check("load.imm", 32'(imm_out), 1);
        check("load.wb_en", 32'(wb_en_out), 0);

        mem_r_en_in = 0; exe_cmd_in = 4'b0010; val_rm_in = 32'h1234;
        step();
        check("frz.pre.exe_cmd", 32'(exe_cmd_out), 4'b0010);
        check("frz.pre.val_rm", val_rm_out, 32'h1234);
        check("frz.pre.ldorst", 32'(ldorst_out), 0);
        freeze = 1; exe_cmd_in = 4'b0100; val_rm_in = 32'hFFFF; mem_w_en_in = 1; valid_in = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("frz%0d.exe_cmd", i), 32'(exe_cmd_out), 4'b0010);
            check($sformatf("frz%0d.val_rm", i), val_rm_out, 32'h1234);
            check($sformatf("frz%0d.valid", i), 32'(valid_out), 1);
            check($sformatf("frz%0d.mem_w", i), 32'(mem_w_en_out), 0);
        end
        freeze = 0; valid_in = 1; mem_w_en_in = 0;
        step();
        check("unfrz.exe_cmd", 32'(exe_cmd_out), 4'b0100);
        check("unfrz.val_rm", val_rm_out, 32'hFFFF);

        mem_w_en_in = 1;
        step();
        check("store.mem_w", 32'(mem_w_en_out), 1);
        check("store.ldorst", 32'(ldorst_out), 1);
        check("store.valid", 32'(valid_out), 1);
        flush = 1; freeze = 1;
        step();
        check_zero("flush_frz");

        flush = 0; freeze = 0; valid_in = 0; wb_en_in = 1; b_in = 1; pc_in = 32'h200;
        step();
        check_zero("bubble");

        valid_in = 1; wb_en_in = 1; b_in = 0; mem_w_en_in = 0; dest_in = 4'd7;
        step();
        check("rf.pre.wb_en", 32'(wb_en_out), 1);
        check("rf.pre.dest", 32'(dest_out), 7);
        freeze = 1; dest_in = 4'd1;
        step();
        check("rf.hold.dest", 32'(dest_out), 7);
        rst = 1;
        step();
        rst = 0;
        check_zero("rst_frz");
        step(); step();
        check_zero("rst_frz.hold");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
